canvas_grid_capture: RTL and testbench

Downstream of the drawing datapath. Consumes every plotted or erased VGA pixel coordinate and maintains a 28x28 binary image of the 140x196 canvas, one bit per 5x7 pixel cell. On request, it streams that image to the network front-end as 784 serial bits with ready/valid handshake. It also keeps a running count of inked cells so the control FSM can reject empty drawings.

---
 rtl/canvas_grid_capture.sv | 151 +++++++++++++++
 tb/tb_canvas_grid_capture.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/canvas_grid_capture.sv
// Maintains a 28x28 binary image of the drawing canvas from plotted pixels,
// tracks how many cells are inked, and streams the image out bit-serially.
module canvas_grid_capture (
  input  logic       clock,
  input  logic       resetn,
  input  logic       plot,
  input  logic       ink,
  input  logic [7:0] x_in,
  input  logic [7:0] y_in,
  input  logic       clear,
  input  logic       start,
  input  logic       out_ready,
  output logic       out_valid,
  output logic       out_bit,
  output logic       out_last,
  output logic       busy,
  output logic [9:0] ink_count
);

  localparam logic [7:0] CANVAS_X0 = 8'd89;
  localparam logic [7:0] CANVAS_Y0 = 8'd33;
  localparam logic [7:0] CANVAS_X1 = 8'd228;
  localparam logic [7:0] CANVAS_Y1 = 8'd228;
  localparam logic [7:0] CELL_W    = 8'd5;
  localparam logic [7:0] CELL_H    = 8'd7;
  localparam logic [9:0] GRID      = 10'd28;
  localparam logic [9:0] LAST_IDX  = 10'd783;

  typedef enum logic [1:0] {IDLE, DRAIN, STREAM} state_t;

  state_t       state_q;
  logic         plot_q;
  logic         ink_q;
  logic [7:0]   dx_q;
  logic [7:0]   dy_q;
  logic [783:0] grid_q;
  logic [9:0]   count_q;
  logic [9:0]   index_q;
  logic         out_valid_q;
  logic         out_bit_q;
  logic         out_last_q;

  logic         inCanvas;
  logic         accept;
  logic         clearAcc;
  logic         plot_d;
  logic [7:0]   dx_d;
  logic [7:0]   dy_d;
  logic [7:0]   col;
  logic [7:0]   row;
  logic [9:0]   cellIdx;
  logic [9:0]   nextIdx;
  logic         oldBit;

  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign out_last  = out_last_q;
  assign ink_count = count_q;

  assign inCanvas = (x_in >= CANVAS_X0) && (x_in <= CANVAS_X1) &&
                    (y_in >= CANVAS_Y0) && (y_in <= CANVAS_Y1);
  assign accept   = !busy && !start && !clear;
  assign clearAcc = clear && !busy;
  assign plot_d   = plot && inCanvas && accept;
  assign dx_d     = x_in - CANVAS_X0;
  assign dy_d     = y_in - CANVAS_Y0;

  // Constant division is exact over the canvas offsets (dx < 140, dy < 196).
  assign col     = dx_q / CELL_W;
  assign row     = dy_q / CELL_H;
  assign cellIdx = {2'b00, row} * GRID + {2'b00, col};
  assign oldBit  = grid_q[cellIdx];
  assign nextIdx = index_q + 10'd1;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      plot_q <= 1'b0;
      ink_q  <= 1'b0;
      dx_q   <= '0;
      dy_q   <= '0;
    end else begin
      plot_q <= plot_d;
      ink_q  <= ink;
      dx_q   <= dx_d;
      dy_q   <= dy_d;
    end
  end

  // An accepted clear also discards the stage-1 write that would land this edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      grid_q  <= '0;
      count_q <= '0;
    end else if (clearAcc) begin
      grid_q  <= '0;
      count_q <= '0;
    end else if (plot_q) begin
      grid_q[cellIdx] <= ink_q;
      if (ink_q && !oldBit) begin
        count_q <= count_q + 10'd1;
      end else if (!ink_q && oldBit) begin
        count_q <= count_q - 10'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      index_q     <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          state_q     <= STREAM;
          index_q     <= '0;
          out_valid_q <= 1'b1;
          out_bit_q   <= grid_q[0];
          out_last_q  <= 1'b0;
        end
        STREAM: begin
          if (out_ready) begin
            if (index_q == LAST_IDX) begin
              state_q     <= IDLE;
              index_q     <= '0;
              out_valid_q <= 1'b0;
              out_bit_q   <= 1'b0;
              out_last_q  <= 1'b0;
            end else begin
              index_q    <= nextIdx;
              out_bit_q  <= grid_q[nextIdx];
              out_last_q <= (nextIdx == LAST_IDX);
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_canvas_grid_capture.sv
// Self-checking bench for canvas_grid_capture: an event-level image model is
// compared against the DUT every cycle, plus directed literal checks.
module tb_canvas_grid_capture;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       plot = 1'b0;
  logic       ink = 1'b0;
  logic [7:0] x_in = '0;
  logic [7:0] y_in = '0;
  logic       clear = 1'b0;
  logic       start = 1'b0;
  logic       out_ready = 1'b1;
  logic       out_valid;
  logic       out_bit;
  logic       out_last;
  logic       busy;
  logic [9:0] ink_count;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  canvas_grid_capture dut (
    .clock     (clock),
    .resetn    (resetn),
    .plot      (plot),
    .ink       (ink),
    .x_in      (x_in),
    .y_in      (y_in),
    .clear     (clear),
    .start     (start),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_bit   (out_bit),
    .out_last  (out_last),
    .busy      (busy),
    .ink_count (ink_count)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: image as an array, one pending pixel, and a readout
  // phase (0 idle, 1 drain, 2 stream) with a snapshot taken when streaming begins.
  bit mGrid[784];
  bit snap[784];
  int mCount;
  int phase;
  int k;
  bit pend;
  int pCell;
  bit pInk;
  bit mIdle;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      foreach (mGrid[i]) mGrid[i] = 1'b0;
      mCount = 0;
      phase  = 0;
      k      = 0;
      pend   = 1'b0;
    end else begin
      mIdle = (phase == 0);
      if (clear && mIdle) begin
        foreach (mGrid[i]) mGrid[i] = 1'b0;
        mCount = 0;
      end else if (pend && mGrid[pCell] != pInk) begin
        mGrid[pCell] = pInk;
        mCount += pInk ? 1 : -1;
      end
      pend  = plot && mIdle && !start && !clear &&
              x_in >= 89 && x_in <= 228 && y_in >= 33 && y_in <= 228;
      pCell = ((int'(y_in) - 33) / 7) * 28 + (int'(x_in) - 89) / 5;
      pInk  = ink;
      if (phase == 0) begin
        if (start) phase = 1;
      end else if (phase == 1) begin
        snap  = mGrid;
        k     = 0;
        phase = 2;
      end else if (out_ready) begin
        k++;
        if (k == 784) begin
          k     = 0;
          phase = 0;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (resetn) begin
      check("inkCount", int'(ink_count), mCount);
      check("busy", int'(busy), int'(phase != 0));
      check("outValid", int'(out_valid), int'(phase == 2));
      if (phase == 2) begin
        check($sformatf("outBit[%0d]", k), int'(out_bit), int'(snap[k]));
        check($sformatf("outLast[%0d]", k), int'(out_last), int'(k == 783));
      end
    end
  end

  bit streamBits[784];
  int streamOnes;
  int lastCnt;
  int lastAt;
  int busyCycles;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic plotPx(input int x, input int y, input bit v);
    plot = 1'b1;
    ink  = v;
    x_in = x[7:0];
    y_in = y[7:0];
    tick();
    plot = 1'b0;
  endtask

  task automatic readout(input bit doStart, input bit stalls, input bit noise);
    int xfers = 0;
    busyCycles = 0;
    lastCnt    = 0;
    lastAt     = -1;
    streamOnes = 0;
    if (doStart) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    while (busy && busyCycles < 6000) begin
      busyCycles++;
      out_ready = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (noise) begin
        plot  = 1'($urandom_range(0, 1));
        ink   = 1'($urandom_range(0, 1));
        x_in  = 8'($urandom_range(89, 228));
        y_in  = 8'($urandom_range(33, 228));
        clear = ($urandom_range(0, 7) == 0);
        start = ($urandom_range(0, 7) == 0);
      end
      if (out_valid && out_ready) begin
        if (xfers < 784) streamBits[xfers] = out_bit;
        if (out_bit) streamOnes++;
        xfers++;
        if (out_last) begin
          lastCnt++;
          lastAt = xfers;
        end
      end
      tick();
    end
    plot      = 1'b0;
    clear     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    check("readoutEnds", int'(busy), 0);
    check("readoutXfers", xfers, 784);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clock);
    #1;
    check("rstOutValid", int'(out_valid), 0);
    check("rstOutBit", int'(out_bit), 0);
    check("rstOutLast", int'(out_last), 0);
    check("rstBusy", int'(busy), 0);
    check("rstInkCount", int'(ink_count), 0);
    resetn = 1'b1;
    tick();

    // Empty readout, then a start in the first idle cycle after it.
    readout(1'b1, 1'b0, 1'b0);
    check("emptyBusyCycles", busyCycles, 785);
    check("emptyLastCnt", lastCnt, 1);
    check("emptyLastAt", lastAt, 784);
    check("emptyOnes", streamOnes, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restartBusy", int'(busy), 1);
    readout(1'b0, 1'b0, 1'b0);

    // Corners and an interior cell, then pixels just outside the canvas.
    plotPx(89, 33, 1'b1);
    plotPx(228, 228, 1'b1);
    plotPx(94, 40, 1'b1);
    tick();
    tick();
    check("cornerCount", int'(ink_count), 3);
    check("modelCell0", int'(mGrid[0]), 1);
    check("modelCell783", int'(mGrid[783]), 1);
    check("modelCell29", int'(mGrid[29]), 1);
    plotPx(88, 33, 1'b1);
    plotPx(229, 100, 1'b1);
    plotPx(100, 32, 1'b1);
    tick();
    tick();
    check("outsideCount", int'(ink_count), 3);
    readout(1'b1, 1'b0, 1'b0);
    check("streamCell0", int'(streamBits[0]), 1);
    check("streamCell783", int'(streamBits[783]), 1);
    check("streamCell29", int'(streamBits[29]), 1);
    check("streamOnes3", streamOnes, 3);

    // Fill every pixel of cell (row 2, col 3) back-to-back, then erase one.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    plot  = 1'b1;
    ink   = 1'b1;
    for (int y = 47; y <= 53; y++) begin
      for (int x = 104; x <= 108; x++) begin
        x_in = 8'(x);
        y_in = 8'(y);
        tick();
      end
    end
    plot = 1'b0;
    tick();
    tick();
    check("fullCellCount", int'(ink_count), 1);
    check("modelCell59", int'(mGrid[59]), 1);
    readout(1'b1, 1'b0, 1'b0);
    check("streamCell59", int'(streamBits[59]), 1);
    plotPx(106, 50, 1'b0);
    tick();
    tick();
    check("eraseCount", int'(ink_count), 0);

    // Random draw/erase stream with occasional clears.
    for (int i = 0; i < 5000; i++) begin
      plot  = ($urandom_range(0, 9) != 0);
      ink   = 1'($urandom_range(0, 1));
      x_in  = 8'($urandom_range(80, 235));
      y_in  = 8'($urandom_range(25, 235));
      clear = ($urandom_range(0, 199) == 0);
      tick();
    end
    plot  = 1'b0;
    clear = 1'b0;
    tick();
    tick();

    // Stalled readout with plot/clear/start noise, then a clean one.
    readout(1'b1, 1'b1, 1'b1);
    readout(1'b1, 1'b0, 1'b0);

    // Plot in the cycle just before start must appear in the stream.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    plot  = 1'b1;
    ink   = 1'b1;
    x_in  = 8'd150;
    y_in  = 8'd100;
    tick();
    plot = 1'b0;
    readout(1'b1, 1'b0, 1'b0);
    check("preStartCell264", int'(streamBits[264]), 1);
    check("preStartOnes", streamOnes, 1);
    check("preStartCount", int'(ink_count), 1);

    // Clear and plot in the same cycle: clear wins.
    plotPx(120, 60, 1'b1);
    plot  = 1'b1;
    ink   = 1'b1;
    x_in  = 8'd200;
    y_in  = 8'd200;
    clear = 1'b1;
    tick();
    plot  = 1'b0;
    clear = 1'b0;
    tick();
    tick();
    check("clearPlotCount", int'(ink_count), 0);

    // Clear and start together: stream is all zeros.
    plotPx(130, 70, 1'b1);
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    readout(1'b0, 1'b0, 1'b0);
    check("clearStartOnes", streamOnes, 0);

    // Reset in the middle of a stream.
    plotPx(95, 45, 1'b1);
    plotPx(180, 150, 1'b1);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(phase == 2 && k == 400) && n < 2000) begin
      n++;
      tick();
    end
    check("reachIdx400", k, 400);
    check("midCount", int'(ink_count), 2);
    resetn = 1'b0;
    #1;
    check("midRstValid", int'(out_valid), 0);
    check("midRstCount", int'(ink_count), 0);
    check("midRstBusy", int'(busy), 0);
    tick();
    resetn = 1'b1;
    tick();
    readout(1'b1, 1'b0, 1'b0);
    check("postRstOnes", streamOnes, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
